// File: rtl/fir_decim_out_buffer.sv
// fir_decim_out_buffer: output stage behind the 123-tap FIR filter.
// Drops the filter fill transient, decimates by DECIM, saturates to OUT_W
// and queues results in a first-word-fall-through FIFO with valid/ready.
// Optional build macro FIR_DECIM_AVG_EN: average each group of DECIM samples
// instead of picking one (DECIM must then be a power of 2).
module fir_decim_out_buffer #(
    parameter int DECIM = 4,
    parameter int SKIP  = 123,
    parameter int DEPTH = 8,
    parameter int IN_W  = 17,
    parameter int OUT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [IN_W-1:0]   in_sample,
    input  logic                     in_valid,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int CNT_W = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
`ifdef FIR_DECIM_AVG_EN
    localparam int LOG_D = $clog2(DECIM);
    localparam int SAT_W = IN_W + LOG_D;
`else
    localparam int SAT_W = IN_W;
`endif
    localparam logic signed [SAT_W-1:0] SAT_MAX = SAT_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SAT_W-1:0] SAT_MIN = SAT_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic {
        WARMUP,
        RUN
    } state_t;

    // With nothing to skip there is no warm-up, so reset lands directly in RUN.
    localparam state_t RESET_STATE = (SKIP == 0) ? RUN : WARMUP;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        skip_cnt_q, skip_cnt_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic signed [OUT_W-1:0] mem_q [DEPTH];
    logic signed [OUT_W-1:0] mem_d [DEPTH];
    logic                    overflow_q, overflow_d;
`ifdef FIR_DECIM_AVG_EN
    logic signed [SAT_W-1:0] acc_q, acc_d;
    logic signed [SAT_W-1:0] acc_sum;
`endif

    logic                    keep;
    logic signed [SAT_W-1:0] sat_in;
    logic signed [OUT_W-1:0] push_val;
    logic                    empty;
    logic                    full;
    logic                    pop;
    logic                    do_push;
    logic                    ovf_set;

    // Warm-up discard, decimation phase and selection of the sample to push.
    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        phase_d    = phase_q;
        keep       = 1'b0;
        sat_in     = '0;
`ifdef FIR_DECIM_AVG_EN
        acc_d      = acc_q;
        acc_sum    = acc_q + SAT_W'(in_sample);
`endif
        case (state_q)
            WARMUP: begin
                if (in_valid) begin
                    skip_cnt_d = skip_cnt_q + 1'b1;
                    if (skip_cnt_d == CNT_W'(SKIP)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (in_valid) begin
                    phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
`ifdef FIR_DECIM_AVG_EN
                    if (phase_q == PH_W'(DECIM - 1)) begin
                        keep   = 1'b1;
                        sat_in = acc_sum >>> LOG_D;
                        acc_d  = '0;
                    end else begin
                        acc_d  = acc_sum;
                    end
`else
                    if (phase_q == '0) begin
                        keep   = 1'b1;
                        sat_in = in_sample;
                    end
`endif
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Clamp the selected value into the signed OUT_W output range.
    always_comb begin
        if (sat_in > SAT_MAX) begin
            push_val = SAT_MAX[OUT_W-1:0];
        end else if (sat_in < SAT_MIN) begin
            push_val = SAT_MIN[OUT_W-1:0];
        end else begin
            push_val = sat_in[OUT_W-1:0];
        end
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // FIFO bookkeeping: a pop frees a slot in the same cycle, so full+push+pop is accepted.
    always_comb begin
        pop        = !empty && out_ready;
        do_push    = keep && (!full || pop);
        ovf_set    = keep && full && !pop;
        mem_d      = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_val;
        end
        wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        overflow_d = overflow_q;
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Control state registers; reset restarts warm-up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RESET_STATE;
            skip_cnt_q <= '0;
            phase_q    <= '0;
`ifdef FIR_DECIM_AVG_EN
            acc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            phase_q    <= phase_d;
`ifdef FIR_DECIM_AVG_EN
            acc_q      <= acc_d;
`endif
        end
    end

    // FIFO storage, pointers and sticky overflow; reset flushes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_q      <= '{default: '0};
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid  = !empty;
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_decim_out_buffer.sv
// Self-checking bench for fir_decim_out_buffer: queue-based reference model
// checked every cycle, plus directed vectors with literal expected values.
// Honours the FIR_DECIM_AVG_EN build macro.
module tb_fir_decim_out_buffer;

    localparam int DECIM  = 4;
    localparam int SKIP   = 123;
    localparam int DEPTH  = 8;
    localparam int IN_W   = 17;
    localparam int OUT_W  = 16;
    localparam int FILLER = 7777;
`ifdef FIR_DECIM_AVG_EN
    localparam bit AVG_MODE = 1'b1;
`else
    localparam bit AVG_MODE = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [IN_W-1:0]  in_sample;
    logic                    in_valid;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic                    overflow;
    logic                    clr_ovf;

    int vectors     = 0;
    int miscompares = 0;
    int nValid      = 0;

    fir_decim_out_buffer #(
        .DECIM(DECIM), .SKIP(SKIP), .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .in_sample(in_sample), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_level(fifo_level), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Reference model state.
    int      mq[$];
    bit      mOvf;
    int      mCount;
    longint  mAcc;
    bit      mPop;
    bit      mPush;
    int      mVal;
    int      mIdx;
    int      mSample;

    function automatic int satv(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic longint floorDiv(input longint a, input int b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference model: count valid samples since reset, keep per the decimation rule, queue results.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mOvf   = 1'b0;
            mCount = 0;
            mAcc   = 0;
        end else begin
            mPop  = (mq.size() > 0) && (out_ready === 1'b1);
            mPush = 1'b0;
            mVal  = 0;
            if (in_valid === 1'b1) begin
                if (mCount >= SKIP) begin
                    mIdx    = mCount - SKIP;
                    mSample = in_sample;
                    if (AVG_MODE) begin
                        mAcc = mAcc + mSample;
                        if (mIdx % DECIM == DECIM - 1) begin
                            mPush = 1'b1;
                            mVal  = satv(floorDiv(mAcc, DECIM));
                            mAcc  = 0;
                        end
                    end else if (mIdx % DECIM == 0) begin
                        mPush = 1'b1;
                        mVal  = satv(mSample);
                    end
                end
                mCount = mCount + 1;
            end
            if (mPop) void'(mq.pop_front());
            if (mPush && mq.size() >= DEPTH) begin
                mOvf = 1'b1;
            end else begin
                if (mPush) mq.push_back(mVal);
                if (clr_ovf === 1'b1) mOvf = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare DUT outputs against the model every falling edge.
    always @(negedge clk) begin
        checkOutput("model out_valid", {31'b0, out_valid}, (mq.size() > 0) ? 1 : 0);
        checkOutput("model fifo_level", {28'b0, fifo_level}, mq.size());
        checkOutput("model overflow", {31'b0, overflow}, {31'b0, mOvf});
        if (mq.size() > 0) checkOutput("model out_data", out_data, mq[0]);
    end

    task automatic applyStimulus(input bit valid, input int sample, input bit ready, input bit clr);
        in_valid  = valid;
        in_sample = IN_W'(sample);
        out_ready = ready;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
        if (valid && rst) nValid = nValid + 1;
    endtask

    function automatic bit nextKept();
        return (nValid >= SKIP) && ((nValid - SKIP) % DECIM == 0);
    endfunction

    task automatic feedKept(input int value, input bit ready);
        while (!nextKept()) applyStimulus(1'b1, FILLER, ready, 1'b0);
        applyStimulus(1'b1, value, ready, 1'b0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_sample = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", {31'b0, out_valid}, 0);
        checkOutput("reset fifo_level", {28'b0, fifo_level}, 0);
        checkOutput("reset overflow", {31'b0, overflow}, 0);
        checkOutput("reset out_data", out_data, 0);
        rst = 1'b1;

`ifdef FIR_DECIM_AVG_EN
        for (int k = 0; k < SKIP; k++) applyStimulus(1'b1, 0, 1'b1, 1'b0);
        checkOutput("avg warmup empty", {31'b0, out_valid}, 0);
        applyStimulus(1'b1, 10, 1'b1, 1'b0);
        applyStimulus(1'b1, 20, 1'b1, 1'b0);
        applyStimulus(1'b1, 30, 1'b1, 1'b0);
        checkOutput("avg partial empty", {31'b0, out_valid}, 0);
        applyStimulus(1'b1, 41, 1'b1, 1'b0);
        checkOutput("avg positive", out_data, 25);
        checkOutput("avg valid", {31'b0, out_valid}, 1);
        applyStimulus(1'b1, -1, 1'b1, 1'b0);
        applyStimulus(1'b1, -1, 1'b1, 1'b0);
        applyStimulus(1'b1, -1, 1'b1, 1'b0);
        applyStimulus(1'b1, -2, 1'b1, 1'b0);
        checkOutput("avg negative floor", out_data, -2);
        repeat (4) applyStimulus(1'b1, 40000, 1'b1, 1'b0);
        checkOutput("avg sat high", out_data, 32767);
        repeat (4) applyStimulus(1'b1, -40000, 1'b1, 1'b0);
        checkOutput("avg sat low", out_data, -32768);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("avg drained", {31'b0, out_valid}, 0);
`else
        // Warm-up discard then pick-one decimation of a ramp.
        for (int k = 0; k < 132; k++) begin
            applyStimulus(1'b1, k, 1'b1, 1'b0);
            if (k == 122) checkOutput("warmup nothing emitted", {31'b0, out_valid}, 0);
            if (k == 123) checkOutput("first kept", out_data, 123);
            if (k == 123) checkOutput("first kept valid", {31'b0, out_valid}, 1);
            if (k == 127) checkOutput("second kept", out_data, 127);
            if (k == 131) checkOutput("third kept", out_data, 131);
        end

        // Saturation on kept samples.
        feedKept(40000, 1'b1);
        checkOutput("sat high", out_data, 32767);
        feedKept(-40000, 1'b1);
        checkOutput("sat low", out_data, -32768);
        feedKept(-5, 1'b1);
        checkOutput("sat passthrough", out_data, -5);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);

        // Overflow: nine kept samples into an eight-deep FIFO with no consumer.
        for (int i = 0; i < 9; i++) feedKept(100 + i, 1'b0);
        checkOutput("ovf level", {28'b0, fifo_level}, 8);
        checkOutput("ovf flag", {31'b0, overflow}, 1);
        checkOutput("ovf head", out_data, 100);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);
        checkOutput("ovf cleared", {31'b0, overflow}, 0);
        // Set wins over a simultaneous clear.
        while (!nextKept()) applyStimulus(1'b1, FILLER, 1'b0, 1'b0);
        applyStimulus(1'b1, 150, 1'b0, 1'b1);
        checkOutput("ovf set priority", {31'b0, overflow}, 1);
        applyStimulus(1'b0, 0, 1'b0, 1'b1);

        // Full with simultaneous push and pop.
        while (!nextKept()) applyStimulus(1'b1, FILLER, 1'b0, 1'b0);
        applyStimulus(1'b1, 200, 1'b1, 1'b0);
        checkOutput("full pushpop level", {28'b0, fifo_level}, 8);
        checkOutput("full pushpop overflow", {31'b0, overflow}, 0);
        checkOutput("full pushpop head", out_data, 101);
        repeat (7) applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("drain last", out_data, 200);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("drain empty", {28'b0, fifo_level}, 0);

        // Asynchronous reset with five entries queued.
        for (int i = 0; i < 5; i++) feedKept(300 + i, 1'b0);
        checkOutput("pre-reset level", {28'b0, fifo_level}, 5);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async reset out_valid", {31'b0, out_valid}, 0);
        checkOutput("async reset level", {28'b0, fifo_level}, 0);
        checkOutput("async reset out_data", out_data, 0);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        nValid = 0;
        for (int k = 0; k < 124; k++) begin
            applyStimulus(1'b1, k, 1'b1, 1'b0);
            if (k == 122) checkOutput("rewarm nothing emitted", {31'b0, out_valid}, 0);
            if (k == 123) checkOutput("rewarm first kept", out_data, 123);
        end
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
`endif

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
